// File: rtl/jtag_dtm_pkg.sv
// Shared types and constants for the RISC-V JTAG DTM TAP.
// The optional IDCODE instruction is controlled by JTAG_DTM_IDCODE_EN (see jtag_dtm_tap).
package jtag_dtm_pkg;

  typedef enum logic [3:0] {
    TAP_TLR,      TAP_RTI,
    TAP_SEL_DR,   TAP_CAP_DR,   TAP_SHIFT_DR, TAP_EXIT1_DR,
    TAP_PAUSE_DR, TAP_EXIT2_DR, TAP_UPD_DR,
    TAP_SEL_IR,   TAP_CAP_IR,   TAP_SHIFT_IR, TAP_EXIT1_IR,
    TAP_PAUSE_IR, TAP_EXIT2_IR, TAP_UPD_IR
  } tap_state_e;

  localparam int IR_W = 5;

  localparam logic [IR_W-1:0] IR_IDCODE  = 5'h01;
  localparam logic [IR_W-1:0] IR_DTMCS   = 5'h10;
  localparam logic [IR_W-1:0] IR_DMI     = 5'h11;
  localparam logic [IR_W-1:0] IR_BYPASS  = 5'h1F;
  localparam logic [IR_W-1:0] IR_CAPTURE = 5'b00001;

  localparam logic [1:0] DMI_OP_NOP   = 2'd0;
  localparam logic [1:0] DMI_OP_READ  = 2'd1;
  localparam logic [1:0] DMI_OP_WRITE = 2'd2;

  localparam logic [1:0] DMI_STAT_OK     = 2'd0;
  localparam logic [1:0] DMI_STAT_FAILED = 2'd2;
  localparam logic [1:0] DMI_STAT_BUSY   = 2'd3;

  localparam int DTMCS_DMIRESET_BIT  = 16;
  localparam int DTMCS_HARDRESET_BIT = 17;

  localparam logic [3:0] DTM_VERSION = 4'd1;

endpackage

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 16-state TAP controller with decoded IR/DR strobes.
module jtag_tap_fsm
  import jtag_dtm_pkg::*;
(
  input  logic tck,
  input  logic rst,
  input  logic tms,
  output logic test_logic_reset,
  output logic capture_ir,
  output logic shift_ir,
  output logic update_ir,
  output logic capture_dr,
  output logic shift_dr,
  output logic update_dr
);

  tap_state_e state, state_nxt;

  // State register; reset parks the TAP in Test-Logic-Reset.
  always_ff @(posedge tck) begin
    if (rst) state <= TAP_TLR;
    else     state <= state_nxt;
  end

  // Next-state on TMS and strobes decoded from the current state.
  always_comb begin
    state_nxt        = state;
    test_logic_reset = (state == TAP_TLR);
    capture_ir       = (state == TAP_CAP_IR);
    shift_ir         = (state == TAP_SHIFT_IR);
    update_ir        = (state == TAP_UPD_IR);
    capture_dr       = (state == TAP_CAP_DR);
    shift_dr         = (state == TAP_SHIFT_DR);
    update_dr        = (state == TAP_UPD_DR);
    unique case (state)
      TAP_TLR:      state_nxt = tms ? TAP_TLR      : TAP_RTI;
      TAP_RTI:      state_nxt = tms ? TAP_SEL_DR   : TAP_RTI;
      TAP_SEL_DR:   state_nxt = tms ? TAP_SEL_IR   : TAP_CAP_DR;
      TAP_CAP_DR:   state_nxt = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
      TAP_SHIFT_DR: state_nxt = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
      TAP_EXIT1_DR: state_nxt = tms ? TAP_UPD_DR   : TAP_PAUSE_DR;
      TAP_PAUSE_DR: state_nxt = tms ? TAP_EXIT2_DR : TAP_PAUSE_DR;
      TAP_EXIT2_DR: state_nxt = tms ? TAP_UPD_DR   : TAP_SHIFT_DR;
      TAP_UPD_DR:   state_nxt = tms ? TAP_SEL_DR   : TAP_RTI;
      TAP_SEL_IR:   state_nxt = tms ? TAP_TLR      : TAP_CAP_IR;
      TAP_CAP_IR:   state_nxt = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
      TAP_SHIFT_IR: state_nxt = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
      TAP_EXIT1_IR: state_nxt = tms ? TAP_UPD_IR   : TAP_PAUSE_IR;
      TAP_PAUSE_IR: state_nxt = tms ? TAP_EXIT2_IR : TAP_PAUSE_IR;
      TAP_EXIT2_IR: state_nxt = tms ? TAP_UPD_IR   : TAP_SHIFT_IR;
      TAP_UPD_IR:   state_nxt = tms ? TAP_SEL_DR   : TAP_RTI;
      default:      state_nxt = TAP_TLR;
    endcase
  end

endmodule

// File: rtl/jtag_dtm_tap.sv
// RISC-V JTAG DTM: TAP, IR/IDCODE/BYPASS/DTMCS/DMI registers and the DMI
// valid/ready request + response interface toward the Debug Module.
// Define JTAG_DTM_IDCODE_EN to include the IDCODE instruction; without it
// IR resets to BYPASS and 0x01 decodes as BYPASS.
module jtag_dtm_tap
  import jtag_dtm_pkg::*;
#(
  parameter int          ABITS       = 7,
  parameter logic [31:0] IDCODE_VAL  = 32'h1000_0CFD,
  parameter int          IDLE_CYCLES = 1
) (
  input  logic             TCK,
  input  logic             RST,
  input  logic             TMS,
  input  logic             TDI,
  output logic             TDO,
  output logic             TDO_EN,
  output logic             DMI_REQ_VALID,
  input  logic             DMI_REQ_READY,
  output logic [ABITS-1:0] DMI_REQ_ADDR,
  output logic [31:0]      DMI_REQ_DATA,
  output logic [1:0]       DMI_REQ_OP,
  input  logic             DMI_RSP_VALID,
  input  logic [31:0]      DMI_RSP_DATA,
  input  logic [1:0]       DMI_RSP_OP
);

  localparam int DRW = ABITS + 34;
  localparam int LW  = $clog2(DRW);

  // Field order matches the DMI scan register, so a scan casts straight in.
  typedef struct packed {
    logic [ABITS-1:0] addr;
    logic [31:0]      data;
    logic [1:0]       op;
  } dmi_req_t;

  logic tlr, capture_ir, shift_ir, update_ir, capture_dr, shift_dr, update_dr;

  logic [IR_W-1:0] ir, ir_sr;
  logic [DRW-1:0]  dr_sr, dr_cap, dr_nxt;
  logic [LW-1:0]   dr_msb;
  logic            is_idcode, is_dtmcs, is_dmi;

  dmi_req_t    req, upd;
  logic        req_valid, outstanding;
  logic [1:0]  dmistat;
  logic [31:0] rsp_buf, dtmcs;

  jtag_tap_fsm u_fsm (
    .tck              (TCK),
    .rst              (RST),
    .tms              (TMS),
    .test_logic_reset (tlr),
    .capture_ir       (capture_ir),
    .shift_ir         (shift_ir),
    .update_ir        (update_ir),
    .capture_dr       (capture_dr),
    .shift_dr         (shift_dr),
    .update_dr        (update_dr)
  );

`ifdef JTAG_DTM_IDCODE_EN
  localparam logic [IR_W-1:0] IR_RESET = IR_IDCODE;
  assign is_idcode = (ir == IR_IDCODE);
`else
  localparam logic [IR_W-1:0] IR_RESET = IR_BYPASS;
  assign is_idcode = 1'b0;
`endif

  assign is_dtmcs = (ir == IR_DTMCS);
  assign is_dmi   = (ir == IR_DMI);
  assign upd      = dmi_req_t'(dr_sr);

  assign dtmcs = {14'b0, 1'b0, 1'b0, 1'b0, 3'(IDLE_CYCLES), dmistat,
                  6'(ABITS), DTM_VERSION};

  // Capture value and length of the selected DR; shift inserts TDI at its MSB.
  always_comb begin
    dr_cap = '0;
    dr_msb = '0;
    if (is_idcode) begin
      dr_cap[31:0] = IDCODE_VAL;
      dr_msb       = LW'(31);
    end else if (is_dtmcs) begin
      dr_cap[31:0] = dtmcs;
      dr_msb       = LW'(31);
    end else if (is_dmi) begin
      dr_cap = {req.addr, rsp_buf, (outstanding ? DMI_STAT_BUSY : dmistat)};
      dr_msb = LW'(DRW - 1);
    end
    dr_nxt         = dr_sr >> 1;
    dr_nxt[dr_msb] = TDI;
  end

  // IR and DR shift paths.
  always_ff @(posedge TCK) begin
    if (RST) begin
      ir    <= IR_RESET;
      ir_sr <= '0;
      dr_sr <= '0;
    end else begin
      if (tlr)        ir    <= IR_RESET;
      if (capture_ir) ir_sr <= IR_CAPTURE;
      if (shift_ir)   ir_sr <= {TDI, ir_sr[IR_W-1:1]};
      if (update_ir)  ir    <= ir_sr;
      if (capture_dr) dr_sr <= dr_cap;
      if (shift_dr)   dr_sr <= dr_nxt;
    end
  end

  // DMI request/response tracking; later statements take priority
  // (hard reset beats a same-cycle response).
  always_ff @(posedge TCK) begin
    if (RST) begin
      req         <= '0;
      req_valid   <= 1'b0;
      outstanding <= 1'b0;
      dmistat     <= DMI_STAT_OK;
      rsp_buf     <= '0;
    end else begin
      if (req_valid && DMI_REQ_READY) req_valid <= 1'b0;
      if (DMI_RSP_VALID && outstanding) begin
        rsp_buf     <= DMI_RSP_DATA;
        outstanding <= 1'b0;
        if (DMI_RSP_OP == DMI_STAT_FAILED && dmistat == DMI_STAT_OK)
          dmistat <= DMI_STAT_FAILED;
      end
      if (capture_dr && is_dmi && outstanding && dmistat == DMI_STAT_OK)
        dmistat <= DMI_STAT_BUSY;
      if (update_dr && is_dtmcs) begin
        if (dr_sr[DTMCS_DMIRESET_BIT] || dr_sr[DTMCS_HARDRESET_BIT])
          dmistat <= DMI_STAT_OK;
        if (dr_sr[DTMCS_HARDRESET_BIT]) begin
          outstanding <= 1'b0;
          req_valid   <= 1'b0;
        end
      end
      if (update_dr && is_dmi && dmistat == DMI_STAT_OK && !outstanding &&
          (upd.op == DMI_OP_READ || upd.op == DMI_OP_WRITE)) begin
        req         <= upd;
        req_valid   <= 1'b1;
        outstanding <= 1'b1;
      end
    end
  end

  assign TDO_EN        = shift_ir | shift_dr;
  assign TDO           = shift_ir ? ir_sr[0] : (shift_dr ? dr_sr[0] : 1'b0);
  assign DMI_REQ_VALID = req_valid;
  assign DMI_REQ_ADDR  = req.addr;
  assign DMI_REQ_DATA  = req.data;
  assign DMI_REQ_OP    = req.op;

endmodule

// File: tb/tb_jtag_dtm_tap.sv
// Randomized self-checking bench for jtag_dtm_tap against a transaction-level
// model of the DTM (dmistat, busy flag, response buffer, pending request).
module tb_jtag_dtm_tap;

  logic        TCK = 1'b0, RST = 1'b1, TMS = 1'b1, TDI = 1'b0;
  logic        TDO, TDO_EN, DMI_REQ_VALID;
  logic        DMI_REQ_READY = 1'b0;
  logic [6:0]  DMI_REQ_ADDR;
  logic [31:0] DMI_REQ_DATA;
  logic [1:0]  DMI_REQ_OP;
  logic        DMI_RSP_VALID = 1'b0;
  logic [31:0] DMI_RSP_DATA = '0;
  logic [1:0]  DMI_RSP_OP = '0;

  jtag_dtm_tap #(.ABITS(7), .IDCODE_VAL(32'h1000_0CFD), .IDLE_CYCLES(1)) dut (
    .TCK(TCK), .RST(RST), .TMS(TMS), .TDI(TDI), .TDO(TDO), .TDO_EN(TDO_EN),
    .DMI_REQ_VALID(DMI_REQ_VALID), .DMI_REQ_READY(DMI_REQ_READY),
    .DMI_REQ_ADDR(DMI_REQ_ADDR), .DMI_REQ_DATA(DMI_REQ_DATA), .DMI_REQ_OP(DMI_REQ_OP),
    .DMI_RSP_VALID(DMI_RSP_VALID), .DMI_RSP_DATA(DMI_RSP_DATA), .DMI_RSP_OP(DMI_RSP_OP)
  );

  always #5 TCK = ~TCK;

`ifdef JTAG_DTM_IDCODE_EN
  localparam bit HAS_IDCODE = 1'b1;
  localparam logic [4:0] IR_RST = 5'h01;
`else
  localparam bit HAS_IDCODE = 1'b0;
  localparam logic [4:0] IR_RST = 5'h1F;
`endif

  int n_chk = 0, n_pass = 0;
  logic s_tdo, s_en;
  logic [4:0] cur_ir;

  // reference model
  logic [1:0]  m_stat;
  logic        m_out, m_valid;
  logic [31:0] m_buf, m_data;
  logic [6:0]  m_addr;
  logic [1:0]  m_op;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_stat = 0; m_out = 0; m_valid = 0; m_buf = 0; m_data = 0; m_addr = 0; m_op = 0;
    cur_ir = IR_RST;
  endtask

  // One TCK: drive on falling edge, sample TDO before the rising edge.
  task automatic tick(input logic tms, input logic tdi);
    @(negedge TCK); TMS = tms; TDI = tdi; #1;
    s_tdo = TDO; s_en = TDO_EN;
    @(posedge TCK); #1;
  endtask

  task automatic dr_scan(input int n, input logic [63:0] din, output logic [63:0] dout);
    dout = '0;
    tick(1, 0); tick(0, 0); tick(0, 0);
    for (int i = 0; i < n; i++) begin
      tick(i == n - 1, din[i]);
      dout[i] = s_tdo;
      if (i == 0) chk("tdo_en", s_en, 1);
    end
    tick(1, 0); tick(0, 0);
  endtask

  task automatic set_ir(input logic [4:0] code);
    logic [4:0] cap;
    tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
    for (int i = 0; i < 5; i++) begin
      tick(i == 4, code[i]);
      cap[i] = s_tdo;
    end
    tick(1, 0); tick(0, 0);
    chk("ir_cap", cap, 5'b00001);
    cur_ir = code;
  endtask

  task automatic chk_req(input string tag);
    chk({tag, ".valid"}, DMI_REQ_VALID, m_valid);
    if (m_valid) chk({tag, ".payload"}, {DMI_REQ_ADDR, DMI_REQ_DATA, DMI_REQ_OP},
                     {m_addr, m_data, m_op});
  endtask

  task automatic dmi_scan(input string tag, input logic [6:0] a, input logic [31:0] d,
                          input logic [1:0] op);
    logic [63:0] dout, exp;
    if (cur_ir != 5'h11) set_ir(5'h11);
    exp = {23'b0, m_addr, m_buf, (m_out ? 2'd3 : m_stat)};
    dr_scan(41, {23'b0, a, d, op}, dout);
    chk({tag, ".cap"}, dout, exp);
    if (m_out && m_stat == 0) m_stat = 3;
    if (m_stat == 0 && !m_out && (op == 1 || op == 2)) begin
      m_out = 1; m_valid = 1; m_addr = a; m_data = d; m_op = op;
    end
    chk_req(tag);
  endtask

  task automatic dtmcs_scan(input string tag, input logic dmireset, input logic hardreset);
    logic [63:0] dout, exp;
    if (cur_ir != 5'h10) set_ir(5'h10);
    exp = {32'b0, 14'b0, 3'b0, 3'd1, m_stat, 6'd7, 4'd1};
    dr_scan(32, {32'b0, 14'b0, hardreset, dmireset, 16'b0}, dout);
    chk({tag, ".cap"}, dout, exp);
    if (dmireset || hardreset) m_stat = 0;
    if (hardreset) begin m_out = 0; m_valid = 0; end
    chk_req(tag);
  endtask

  task automatic accept(input string tag, input int hold);
    for (int k = 0; k < hold; k++) begin
      tick(0, 0);
      chk_req({tag, ".hold"});
    end
    DMI_REQ_READY = 1; tick(0, 0); DMI_REQ_READY = 0;
    m_valid = 0;
    chk_req({tag, ".acc"});
  endtask

  task automatic respond(input logic [31:0] d, input logic [1:0] op);
    DMI_RSP_VALID = 1; DMI_RSP_DATA = d; DMI_RSP_OP = op;
    tick(0, 0);
    DMI_RSP_VALID = 0;
    if (m_out) begin
      m_buf = d; m_out = 0;
      if (op == 2 && m_stat == 0) m_stat = 2;
    end
  endtask

  // After reset/TLR the DR path is IDCODE or a 1-bit bypass.
  task automatic chk_default_dr(input string tag);
    logic [63:0] din, dout;
    din = {32'b0, $urandom()};
    dr_scan(32, din, dout);
    if (HAS_IDCODE) chk(tag, dout, 64'h1000_0CFD);
    else            chk(tag, dout, {32'b0, din[30:0], 1'b0});
  endtask

  initial begin
    logic [63:0] din, dout;
    logic [31:0] r;
    model_reset();
    RST = 1; tick(1, 0); tick(1, 0);
    chk("rst.tdo", {TDO, TDO_EN}, 0);
    chk("rst.valid", DMI_REQ_VALID, 0);
    chk("rst.payload", {DMI_REQ_ADDR, DMI_REQ_DATA, DMI_REQ_OP}, 0);
    RST = 0; tick(0, 0);
    chk_default_dr("rst.dr");
    chk("idle.tdo_en", TDO_EN, 0);

    dtmcs_scan("dtmcs", 0, 0);

    // explicit bypass with an unused opcode
    set_ir(5'($urandom_range(2, 15)));
    din = {56'b0, 8'($urandom())};
    dr_scan(8, din, dout);
    chk("bypass", dout, (din << 1) & 64'hFF);

    // five TMS=1 from Pause-DR reaches TLR and reloads IR
    set_ir(5'h10);
    tick(1, 0); tick(0, 0); tick(1, 0); tick(0, 0);
    for (int i = 0; i < 5; i++) tick(1, 0);
    tick(0, 0); cur_ir = IR_RST;
    chk_default_dr("tlr.dr");

    // write, held unaccepted 3 clocks, then accepted
    dmi_scan("wr", 7'h10, 32'h1, 2'd2);
    accept("wr", 3);

    // busy: capture before response, new update ignored
    dmi_scan("busy", 7'($urandom()), $urandom(), 2'd2);
    dtmcs_scan("busy.st", 1, 0);
    respond(32'hDEAD_BEEF, 0);
    dmi_scan("busy.rd", 0, 0, 0);

    // error: failed read blocks until dmireset
    dmi_scan("err", 7'($urandom()), 0, 2'd1);
    accept("err", 1);
    respond($urandom(), 2);
    dmi_scan("err.cap", 0, 0, 0);
    dmi_scan("err.blk", 7'($urandom()), $urandom(), 2'd2);
    dtmcs_scan("err.clr", 1, 0);

    // acceptance and response in the same cycle
    dmi_scan("same", 7'($urandom()), $urandom(), 2'd1);
    r = $urandom();
    DMI_REQ_READY = 1; DMI_RSP_VALID = 1; DMI_RSP_DATA = r; DMI_RSP_OP = 0;
    tick(0, 0);
    DMI_REQ_READY = 0; DMI_RSP_VALID = 0;
    m_valid = 0; m_out = 0; m_buf = r;
    chk_req("same");
    dmi_scan("same.cap", 0, 0, 0);

    // randomized mix of transactions
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 4))
        0: dmi_scan("rnd.dmi", 7'($urandom()), $urandom(), 2'($urandom()));
        1: accept("rnd.acc", $urandom_range(0, 3));
        2: if (!m_valid) respond($urandom(), $urandom_range(0, 1) ? 2'd2 : 2'd0);
        3: dtmcs_scan("rnd.dtmcs", 1'($urandom()), 1'($urandom()));
        default: dmi_scan("rnd.cap", 0, 0, 0);
      endcase
    end

    // reset mid-transaction
    dtmcs_scan("mid.clr", 0, 1);
    dmi_scan("mid", 7'($urandom()), $urandom(), 2'd2);
    RST = 1; tick(0, 0);
    chk("mid.valid", DMI_REQ_VALID, 0);
    RST = 0; model_reset(); tick(0, 0);
    respond($urandom(), 2);
    dmi_scan("mid.cap", 0, 0, 0);
    dtmcs_scan("mid.st", 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/jtag_dtm_tap.md
Name: jtag_dtm_tap

Overview:
- RISC-V JTAG Debug Transport Module (DTM) TAP for the Mi-V core.
- Sits directly downstream of the JTAG tunnelling core's target port: consumes TGT_TCK/TGT_TMS/TGT_TDI and the active-high TGT_TRSTB, and returns TGT_TDO.
- Implements the IEEE 1149.1 TAP state machine and the IR, IDCODE, BYPASS, DTMCS and DMI registers.
- Converts DMI scans into a valid/ready request and response handshake toward the Debug Module.

Parameters:
- ABITS, 7, DMI address width in bits.
- IDCODE_VAL, 32'h1000_0CFD, IDCODE register value; bit 0 must be 1.
- IDLE_CYCLES, 1, value reported in DTMCS.idle; range 0..7.

Ports:
- TCK  in  1  tunnelled JTAG clock (TGT_TCK); the only clock.
- RST  in  1  reset (TGT_TRSTB, active-high).
- TMS  in  1  test mode select.
- TDI  in  1  test data in.
- TDO  out  1  test data out.
- TDO_EN  out  1  high in Shift-IR and Shift-DR.
- DMI_REQ_VALID  out  1  DMI request valid.
- DMI_REQ_READY  in  1  Debug Module accepts the request.
- DMI_REQ_ADDR  out  ABITS  request address.
- DMI_REQ_DATA  out  32  write data.
- DMI_REQ_OP  out  2  1 = read, 2 = write.
- DMI_RSP_VALID  in  1  response strobe; the DTM is always ready.
- DMI_RSP_DATA  in  32  read data.
- DMI_RSP_OP  in  2  0 = ok, 2 = failed.

Behaviour:
- Clocking and reset: one clock, TCK. Reset is synchronous and active-high (RST).
- Reset state:
  - TAP in Test-Logic-Reset; IR = IDCODE (5'h01).
  - TDO = 0, TDO_EN = 0, DMI_REQ_VALID = 0, ADDR/DATA/OP = 0.
  - dmistat = 0, outstanding = 0, response buffer = 0.
- TAP state machine: the standard 16 states, transitions on TMS at the rising edge of TCK.
  - Five TMS=1 clocks from any state reach Test-Logic-Reset.
  - Entering Test-Logic-Reset reloads IR = IDCODE.
- IR: 5 bits. Capture-IR loads 5'b00001; shift is LSB first; Update-IR commits.
- Instruction decode:
  - 0x01 = IDCODE (32 bits).
  - 0x10 = DTMCS (32 bits).
  - 0x11 = DMI (ABITS+34 bits).
  - All other codes = BYPASS (1 bit, captures 0).
- Shift and TDO:
  - Shift is LSB first; TDO = shift_reg[0], combinational while in a Shift state, otherwise 0.
  - The falling-edge retiming flop lives outside this block.
- DTMCS read: {14'b0, dmihardreset=0, dmireset=0, 1'b0, idle[14:12], dmistat[11:10], abits[9:4], version=4'd1}.
- DTMCS Update-DR:
  - bit16 set clears dmistat.
  - bit17 set clears dmistat and outstanding, withdraws DMI_REQ_VALID even if unaccepted, and discards any late response.
- DMI register layout: {addr[ABITS+33:34], data[33:2], op[1:0]}.
- DMI Capture-DR:
  - addr = last request address; data = response buffer.
  - op = 3 if outstanding, else dmistat.
  - Capturing while outstanding sets sticky dmistat = 3 if it is currently 0.
- DMI Update-DR:
  - If dmistat != 0 or outstanding: ignored.
  - Else, with op 1 or 2: on the next TCK, DMI_REQ_VALID = 1 with ADDR/DATA/OP latched, and outstanding = 1.
  - op 0 or 3: no request.
- Request handshake:
  - VALID and payload are held stable until a cycle with VALID && READY; VALID drops the following cycle.
- Response handling:
  - DMI_RSP_VALID while outstanding latches RSP_DATA into the response buffer and clears outstanding.
  - RSP_OP = 2 sets dmistat = 2 when dmistat = 0.
  - DMI_RSP_VALID while not outstanding is ignored.
  - Response and acceptance in the same cycle are legal: clear outstanding and drop VALID together.
- Reset mid-transaction: RST has priority over everything. It drops VALID immediately and any subsequent response is ignored.

Optional Feature:
- Macro: JTAG_DTM_IDCODE_EN.
- Defined: the IDCODE instruction exists, and reset/Test-Logic-Reset loads IR = 0x01.
- Undefined:
  - 0x01 decodes as BYPASS.
  - Reset and Test-Logic-Reset load IR = 0x1F.
  - Capture-DR in BYPASS captures 0.
  - IDCODE_VAL is unused.

Decomposition:
- Package jtag_dtm_pkg:
  - TAP state enum.
  - IR codes (IR_IDCODE, IR_DTMCS, IR_DMI, IR_BYPASS).
  - DMI op and status constants.
  - DTMCS bit positions and DTM_VERSION.
- Sub-module: jtag_tap_fsm, containing the 16-state machine with decoded capture/shift/update strobes for IR and DR.

Test Plan:
- Reset: RST high for 2 clocks, then Shift-DR for 32 bits -> TDO stream = 32'h1000_0CFD; Capture-IR shifts out 5'b00001.
- DTMCS: IR = 0x10, shift 32 zeros -> 32'h0000_1071 (idle 1, abits 7, version 1).
- DMI write: IR = 0x11, shift addr 0x10, data 0x1, op 2, Update -> next clock DMI_REQ_VALID = 1, ADDR = 0x10, DATA = 1, OP = 2. Hold READY low 3 clocks -> payload stable; READY = 1 -> VALID drops the next clock.
- Busy: capture DMI before the response -> op = 3 and dmistat = 3; a new Update is ignored (no VALID). DTMCS bit16 write -> dmistat = 0; RSP_VALID with data 0xDEADBEEF -> next capture returns data 0xDEADBEEF, op 0.
- Error: a read with RSP_OP = 2 -> captured op = 2 and the next request is blocked until dmireset.
- Reset mid-op: RST asserted while VALID = 1 and READY = 0 -> VALID = 0 the next clock; a later RSP_VALID leaves the buffer and dmistat unchanged.
